// File: rtl/vend_pkg.sv
// Shared vending-machine datapath types: denominations, change FSM states, coin index.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

   localparam int NUM_DENOMS = 5;

   // Denomination values ordered largest first; the index is the hopper coin select.
   localparam int unsigned DENOM [NUM_DENOMS] = '{50, 20, 10, 5, 1};

   typedef logic [2:0] coin_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      ISSUE  = 2'd2,
      DONE   = 2'd3
   } chg_state_t;

   // Value of the coin at a given index; out-of-range indices read as 0.
   function automatic int unsigned denom_of(input coin_idx_t idx);
      case (idx)
         3'd0:    denom_of = 50;
         3'd1:    denom_of = 20;
         3'd2:    denom_of = 10;
         3'd3:    denom_of = 5;
         3'd4:    denom_of = 1;
         default: denom_of = 0;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change request / coin hopper bundle between the vending FSM, change_dispenser and the hopper.
// Latency: n/a (wires only); restock signals exist only with CHANGE_STOCK_EN.
// Backpressure: coin_ready from the hopper stalls coin_valid/coin_sel.
interface change_dispenser_if
   import vend_pkg::*;
#(
   parameter int CURRENCY_WIDTH = 7,
   parameter int STOCK_WIDTH    = 8
);
   logic                      change_req;
   logic [CURRENCY_WIDTH-1:0] change_amount;
   logic                      busy;
   logic                      coin_valid;
   coin_idx_t                 coin_sel;
   logic                      coin_ready;
   logic                      change_done;
   logic                      change_short;
   logic [CURRENCY_WIDTH-1:0] short_amount;
`ifdef CHANGE_STOCK_EN
   logic                      stock_load;
   logic [2:0]                stock_idx;
   logic [STOCK_WIDTH-1:0]    stock_value;
`else
   // Stock width only sizes the restock port, which is absent in this build.
   logic                      unused_stock_cfg;
   assign unused_stock_cfg = STOCK_WIDTH[0];
`endif

   // Environment side: requester, hopper and restock source.
   modport master (
      output change_req, change_amount, coin_ready,
`ifdef CHANGE_STOCK_EN
      output stock_load, stock_idx, stock_value,
`endif
      input  busy, coin_valid, coin_sel, change_done, change_short, short_amount
   );

   // Dispenser side.
   modport slave (
      input  change_req, change_amount, coin_ready,
`ifdef CHANGE_STOCK_EN
      input  stock_load, stock_idx, stock_value,
`endif
      output busy, coin_valid, coin_sel, change_done, change_short, short_amount
   );

endinterface

// File: rtl/change_denom_select.sv
// Priority picker: lowest index whose denomination fits the remaining amount and has stock.
// Latency: combinational.
// Backpressure: none.
module change_denom_select
   import vend_pkg::*;
#(
   parameter int CURRENCY_WIDTH = 7
) (
   input  logic [CURRENCY_WIDTH-1:0] remaining,
   input  logic [NUM_DENOMS-1:0]     stock_nz,
   output logic                      found,
   output coin_idx_t                 idx
);

   // Scan from smallest coin up so the largest fitting coin (lowest index) wins last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_DENOMS - 1; i >= 0; i--) begin
         if (stock_nz[i] && (CURRENCY_WIDTH'(DENOM[i]) <= remaining)) begin
            found = 1'b1;
            idx   = coin_idx_t'(i);
         end
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout: splits an amount into coins and offers them one at a time to the hopper.
// Latency: first coin_valid 2 cycles after change_req; 2 cycles per coin; done 2 cycles for zero.
// Backpressure: coin_ready low holds the offered coin indefinitely. Option macro: CHANGE_STOCK_EN.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int CURRENCY_WIDTH = 7,
   parameter int STOCK_WIDTH    = 8,
   parameter int STOCK_INIT     = 10
) (
   input logic               clk,
   input logic               rst,
   change_dispenser_if.slave bus
);

   chg_state_t                state_q, state_d;
   logic [CURRENCY_WIDTH-1:0] remaining_q, remaining_d;
   coin_idx_t                 coin_sel_q, coin_sel_d;
   logic                      coin_valid_q, coin_valid_d;
   logic                      busy_q, busy_d;
   logic                      change_done_q, change_done_d;
   logic                      change_short_q, change_short_d;
   logic [CURRENCY_WIDTH-1:0] short_amount_q, short_amount_d;

   logic [NUM_DENOMS-1:0]     stock_nz;
   logic                      sel_found;
   coin_idx_t                 sel_idx;
   logic                      handshake;

`ifdef CHANGE_STOCK_EN
   logic [STOCK_WIDTH-1:0]    stock_q [NUM_DENOMS];
   logic [STOCK_WIDTH-1:0]    stock_d [NUM_DENOMS];

   // Denominations with coins left are eligible for selection.
   always_comb begin
      stock_nz = '0;
      for (int i = 0; i < NUM_DENOMS; i++) begin
         stock_nz[i] = (stock_q[i] != '0);
      end
   end
`else
   // Unlimited supply: every denomination is always eligible.
   assign stock_nz = '1;

   // Stock sizing has no effect without stock counters.
   logic unused_stock_cfg;
   assign unused_stock_cfg = STOCK_WIDTH[0] ^ STOCK_INIT[0];
`endif

   change_denom_select #(
      .CURRENCY_WIDTH(CURRENCY_WIDTH)
   ) u_select (
      .remaining(remaining_q),
      .stock_nz (stock_nz),
      .found    (sel_found),
      .idx      (sel_idx)
   );

   // coin_valid is registered and high only in ISSUE, so the state alone qualifies the handshake.
   assign handshake = (state_q == ISSUE) && bus.coin_ready;

   // Next-state and registered-output logic of the payout FSM.
   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      coin_sel_d     = coin_sel_q;
      change_short_d = change_short_q;
      short_amount_d = short_amount_q;

      case (state_q)
         IDLE: begin
            if (bus.change_req) begin
               remaining_d = bus.change_amount;
               state_d     = SELECT;
            end
         end
         SELECT: begin
            if (remaining_q == '0) begin
               change_short_d = 1'b0;
               short_amount_d = '0;
               state_d        = DONE;
            end else if (!sel_found) begin
`ifdef CHANGE_STOCK_EN
               change_short_d = 1'b1;
               short_amount_d = remaining_q;
`else
               change_short_d = 1'b0;
               short_amount_d = '0;
`endif
               state_d        = DONE;
            end else begin
               coin_sel_d = sel_idx;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (handshake) begin
               remaining_d = remaining_q - CURRENCY_WIDTH'(denom_of(coin_sel_q));
               state_d     = SELECT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      coin_valid_d  = (state_d == ISSUE);
      busy_d        = (state_d != IDLE);
      change_done_d = (state_d == DONE);
   end

`ifdef CHANGE_STOCK_EN
   // Stock update: consume on handshake, then let a restock write override the same slot.
   always_comb begin
      stock_d = stock_q;
      for (int i = 0; i < NUM_DENOMS; i++) begin
         if (handshake && (coin_sel_q == coin_idx_t'(i)) && (stock_q[i] != '0)) begin
            stock_d[i] = stock_q[i] - 1'b1;
         end
         if (bus.stock_load && (bus.stock_idx == coin_idx_t'(i))) begin
            stock_d[i] = bus.stock_value;
         end
      end
   end
`endif

   // State and output registers with synchronous reset; reset abandons any coin in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         remaining_q    <= '0;
         coin_sel_q     <= '0;
         coin_valid_q   <= 1'b0;
         busy_q         <= 1'b0;
         change_done_q  <= 1'b0;
         change_short_q <= 1'b0;
         short_amount_q <= '0;
`ifdef CHANGE_STOCK_EN
         for (int i = 0; i < NUM_DENOMS; i++) begin
            stock_q[i] <= STOCK_WIDTH'(STOCK_INIT);
         end
`endif
      end else begin
         state_q        <= state_d;
         remaining_q    <= remaining_d;
         coin_sel_q     <= coin_sel_d;
         coin_valid_q   <= coin_valid_d;
         busy_q         <= busy_d;
         change_done_q  <= change_done_d;
         change_short_q <= change_short_d;
         short_amount_q <= short_amount_d;
`ifdef CHANGE_STOCK_EN
         stock_q        <= stock_d;
`endif
      end
   end

   assign bus.busy         = busy_q;
   assign bus.coin_valid   = coin_valid_q;
   assign bus.coin_sel     = coin_sel_q;
   assign bus.change_done  = change_done_q;
   assign bus.change_short = change_short_q;
   assign bus.short_amount = short_amount_q;

endmodule
